raw_timing_monitor: RTL and testbench

Passive monitor that sits directly downstream of the raw colorbar generator (or a sensor port), sampling `fv`/`lv`/`data`. It measures active width, line period and active line count per frame, compares each against parameters, raises sticky error flags, and reports lock once timing is stable. It never drives or back-pressures the video path.

---
 rtl/raw_timing_monitor_if.sv | 22 ++
 rtl/raw_timing_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_raw_timing_monitor.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raw_timing_monitor_if.sv
// rtl/raw_timing_monitor_if.sv - raw video bus (frame valid, line valid, pixel data)
//
// Purpose: carries the raw video path between a source (generator or sensor
// port) and any passive observer such as raw_timing_monitor.
// Signals:
//   fv    frame valid
//   lv    line valid
//   data  pixel data, word_width bits
// Modports:
//   master  drives the bus (video source)
//   slave   observes the bus (monitor, sink)

interface raw_timing_monitor_if #(
  parameter int word_width = 10
);
  logic                  fv;
  logic                  lv;
  logic [word_width-1:0] data;

  modport master (output fv, output lv, output data);
  modport slave  (input  fv, input  lv, input  data);
endinterface

// File: rtl/raw_timing_monitor.sv
// rtl/raw_timing_monitor.sv - passive raw video timing monitor with lock detect
//
// Purpose: measures active width, line period and active line count of each
// frame on the raw video bus, flags mismatches against the expected timing,
// counts frames and reports lock after lock_frames consecutive clean frames.
// Never drives or stalls the video path.
// Optional feature: define RAW_FRAME_CHECKSUM_EN to build the per-frame 16-bit
// pixel checksum; otherwise o_frame_checksum is tied to 0.
// Ports:
//   i_clk             pixel clock
//   i_rstn            asynchronous active-low reset
//   i_vid             video bus (slave modport): fv, lv, data
//   i_clr_err         synchronous clear of the sticky error flags
//   o_meas_h_active   last measured line width
//   o_meas_h_total    last measured line period
//   o_meas_v_active   lines in the last complete frame
//   o_frame_cnt       completed frames, wrapping
//   o_frame_done      one-cycle pulse per completed frame
//   o_err_h_active    sticky line width mismatch
//   o_err_h_total     sticky line period mismatch
//   o_err_v_active    sticky line count mismatch
//   o_err_lv_no_fv    sticky line valid outside frame valid
//   o_locked          timing stable
//   o_frame_checksum  sum of active pixels of the last frame

module raw_timing_monitor #(
  parameter int word_width  = 10,
  parameter int h_active    = 1280,
  parameter int h_total     = 1650,
  parameter int v_active    = 720,
  parameter int cnt_width   = 12,
  parameter int lock_frames = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  raw_timing_monitor_if.slave   i_vid,
  input  logic                  i_clr_err,
  output logic [cnt_width-1:0]  o_meas_h_active,
  output logic [cnt_width-1:0]  o_meas_h_total,
  output logic [cnt_width-1:0]  o_meas_v_active,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_frame_done,
  output logic                  o_err_h_active,
  output logic                  o_err_h_total,
  output logic                  o_err_v_active,
  output logic                  o_err_lv_no_fv,
  output logic                  o_locked,
  output logic [15:0]           o_frame_checksum
);

  typedef enum logic [1:0] {ST_SYNC, ST_WAIT, ST_FRAME} state_t;

  localparam logic [cnt_width-1:0] c_max      = '1;
  localparam logic [cnt_width-1:0] c_h_active = cnt_width'(h_active);
  localparam logic [cnt_width-1:0] c_h_total  = cnt_width'(h_total);
  localparam logic [cnt_width-1:0] c_v_active = cnt_width'(v_active);
  localparam logic [3:0]           c_lock     = 4'(lock_frames);

  function automatic logic [cnt_width-1:0] f_sat_inc(input logic [cnt_width-1:0] v);
    return (v == c_max) ? v : v + 1'b1;
  endfunction

  // A saturated count can never be trusted, so it always mismatches.
  function automatic logic f_mis(input logic [cnt_width-1:0] v,
                                 input logic [cnt_width-1:0] e);
    return (v == c_max) || (v != e);
  endfunction

  state_t r_state, w_state_nxt;

  // Input stage: s1 samples the bus, s2 is the edge reference.
  logic r_fv1, r_lv1, r_fv2, r_lv2, r_s1_vld;
  // Edge events detected from s1 vs s2, registered so that they line up
  // with the s2 levels used for counting.
  logic r_ev_fv_rise, r_ev_fv_fall, r_ev_lv_rise, r_ev_line_end;

  logic [cnt_width-1:0] r_w_cnt, r_t_cnt, r_l_cnt;
  logic                 r_seen_line, r_frame_bad;
  logic [cnt_width-1:0] r_meas_ha, r_meas_ht, r_meas_va;
  logic [15:0]          r_frame_cnt;
  logic                 r_frame_done, r_done_clean, r_evt_err;
  logic                 r_err_ha, r_err_ht, r_err_va, r_err_nf;
  logic [3:0]           r_clean;
  logic                 r_locked;

  logic                 w_fv_start, w_in_frame, w_frame_end;
  logic                 w_line_start, w_line_end, w_active, w_period_load;
  logic                 w_mis_ha, w_mis_ht, w_mis_va, w_any_mis, w_stray;
  logic [cnt_width-1:0] w_w_base, w_t_base, w_l_base;
  logic [3:0]           w_clean_nxt;

  // The cycle that opens a frame is still in WAIT but already belongs to it.
  assign w_fv_start    = (r_state == ST_WAIT) & r_ev_fv_rise;
  assign w_in_frame    = (r_state == ST_FRAME) | w_fv_start;
  assign w_frame_end   = (r_state == ST_FRAME) & r_ev_fv_fall;
  assign w_line_start  = w_in_frame & r_ev_lv_rise & r_fv2;
  assign w_line_end    = w_in_frame & r_ev_line_end;
  assign w_active      = w_in_frame & r_fv2 & r_lv2;
  assign w_period_load = w_line_start & r_seen_line;

  assign w_mis_ha  = w_line_end    & f_mis(r_w_cnt, c_h_active);
  assign w_mis_ht  = w_period_load & f_mis(r_t_cnt, c_h_total);
  assign w_mis_va  = w_frame_end   & f_mis(r_l_cnt, c_v_active);
  assign w_any_mis = w_mis_ha | w_mis_ht | w_mis_va;
  assign w_stray   = r_lv2 & ~r_fv2;

  assign w_w_base = w_line_start ? '0 : r_w_cnt;
  assign w_t_base = w_line_start ? '0 : r_t_cnt;
  assign w_l_base = w_fv_start   ? '0 : r_l_cnt;

  always_comb begin
    w_clean_nxt = r_clean;
    if (r_evt_err) begin
      w_clean_nxt = '0;
    end else if (r_frame_done && r_done_clean && (r_clean != 4'hF)) begin
      w_clean_nxt = r_clean + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Wait for a frame gap so a partial frame after reset is never measured.
      ST_SYNC:  if (r_s1_vld && !r_fv1) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (r_ev_fv_rise)       w_state_nxt = ST_FRAME;
      ST_FRAME: if (r_ev_fv_fall)       w_state_nxt = ST_WAIT;
      default:                          w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= ST_SYNC;
      r_fv1         <= 1'b0;
      r_lv1         <= 1'b0;
      r_fv2         <= 1'b0;
      r_lv2         <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_ev_fv_rise  <= 1'b0;
      r_ev_fv_fall  <= 1'b0;
      r_ev_lv_rise  <= 1'b0;
      r_ev_line_end <= 1'b0;
      r_w_cnt       <= '0;
      r_t_cnt       <= '0;
      r_l_cnt       <= '0;
      r_seen_line   <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_meas_ha     <= '0;
      r_meas_ht     <= '0;
      r_meas_va     <= '0;
      r_frame_cnt   <= '0;
      r_frame_done  <= 1'b0;
      r_done_clean  <= 1'b0;
      r_evt_err     <= 1'b0;
      r_err_ha      <= 1'b0;
      r_err_ht      <= 1'b0;
      r_err_va      <= 1'b0;
      r_err_nf      <= 1'b0;
      r_clean       <= '0;
      r_locked      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fv1    <= i_vid.fv;
      r_lv1    <= i_vid.lv;
      r_fv2    <= r_fv1;
      r_lv2    <= r_lv1;
      r_s1_vld <= 1'b1;

      r_ev_fv_rise  <= r_fv1 & ~r_fv2;
      r_ev_fv_fall  <= ~r_fv1 & r_fv2;
      r_ev_lv_rise  <= r_lv1 & ~r_lv2;
      // A line also ends when the frame closes underneath it (truncated line).
      r_ev_line_end <= (~r_lv1 & r_lv2) | (~r_fv1 & r_fv2 & r_lv1);

      if (w_in_frame) begin
        r_w_cnt     <= w_active ? f_sat_inc(w_w_base) : w_w_base;
        r_t_cnt     <= f_sat_inc(w_t_base);
        r_l_cnt     <= w_line_start ? f_sat_inc(w_l_base) : w_l_base;
        r_seen_line <= (r_seen_line & ~w_fv_start) | w_line_start;
        r_frame_bad <= (r_frame_bad & ~w_fv_start) | w_any_mis;
      end

      if (w_line_end)    r_meas_ha <= r_w_cnt;
      if (w_period_load) r_meas_ht <= r_t_cnt;
      if (w_frame_end) begin
        r_meas_va   <= r_l_cnt;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      r_frame_done <= w_frame_end;
      r_done_clean <= w_frame_end & ~(r_frame_bad | w_any_mis);
      r_evt_err    <= w_any_mis | w_stray;

      // Set has priority over clear.
      r_err_ha <= w_mis_ha | (r_err_ha & ~i_clr_err);
      r_err_ht <= w_mis_ht | (r_err_ht & ~i_clr_err);
      r_err_va <= w_mis_va | (r_err_va & ~i_clr_err);
      r_err_nf <= w_stray  | (r_err_nf & ~i_clr_err);

      r_clean  <= w_clean_nxt;
      r_locked <= (w_clean_nxt >= c_lock);
    end
  end

`ifdef RAW_FRAME_CHECKSUM_EN
  logic [word_width-1:0] r_data1, r_data2;
  logic [15:0]           r_csum_acc, r_csum;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data1    <= '0;
      r_data2    <= '0;
      r_csum_acc <= '0;
      r_csum     <= '0;
    end else begin
      r_data1 <= i_vid.data;
      r_data2 <= r_data1;
      if (w_in_frame) begin
        r_csum_acc <= (w_fv_start ? 16'd0 : r_csum_acc) +
                      (w_active ? 16'(r_data2) : 16'd0);
      end
      if (w_frame_end) r_csum <= r_csum_acc;
    end
  end

  assign o_frame_checksum = r_csum;
`else
  assign o_frame_checksum = 16'd0;
`endif

  assign o_meas_h_active = r_meas_ha;
  assign o_meas_h_total  = r_meas_ht;
  assign o_meas_v_active = r_meas_va;
  assign o_frame_cnt     = r_frame_cnt;
  assign o_frame_done    = r_frame_done;
  assign o_err_h_active  = r_err_ha;
  assign o_err_h_total   = r_err_ht;
  assign o_err_v_active  = r_err_va;
  assign o_err_lv_no_fv  = r_err_nf;
  assign o_locked        = r_locked;

endmodule

// File: tb/tb_raw_timing_monitor.sv
// tb/tb_raw_timing_monitor.sv - self-checking bench for raw_timing_monitor
`timescale 1ns/1ps

module tb_raw_timing_monitor;

  localparam int WW = 10;
  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 4;
  localparam int CW = 12;
  localparam int LF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          clr_err;
  logic [CW-1:0] meas_h_active, meas_h_total, meas_v_active;
  logic [15:0]   frame_cnt, frame_checksum;
  logic          frame_done, err_h_active, err_h_total, err_v_active, err_lv_no_fv, locked;

  raw_timing_monitor_if #(.word_width(WW)) vid ();

  raw_timing_monitor #(
    .word_width(WW), .h_active(HA), .h_total(HT), .v_active(VA),
    .cnt_width(CW), .lock_frames(LF)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_vid(vid),
    .i_clr_err(clr_err),
    .o_meas_h_active(meas_h_active),
    .o_meas_h_total(meas_h_total),
    .o_meas_v_active(meas_v_active),
    .o_frame_cnt(frame_cnt),
    .o_frame_done(frame_done),
    .o_err_h_active(err_h_active),
    .o_err_h_total(err_h_total),
    .o_err_v_active(err_v_active),
    .o_err_lv_no_fv(err_lv_no_fv),
    .o_locked(locked),
    .o_frame_checksum(frame_checksum)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: expected results of each frame, queued when the
  // frame is sent and consumed when the DUT reports the frame.
  typedef struct {
    int hact; int htot; int vact; int fcnt; int csum; int err; bit lock;
  } exp_t;
  exp_t q_exp[$];

  logic [15:0] m_fcnt;
  int          m_clean, m_hact, m_htot;
  bit          m_eha, m_eht, m_eva, m_enf;
  int          lw[8], lg[8];

  task automatic model_reset();
    q_exp.delete();
    m_fcnt = 0; m_clean = 0; m_hact = 0; m_htot = 0;
    m_eha = 0; m_eht = 0; m_eva = 0; m_enf = 0;
  endtask

  task automatic drive(input bit f, input bit l, input int d);
    vid.fv = f;
    vid.lv = l;
    vid.data = d[WW-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic set_nominal(input int n);
    for (int i = 0; i < n; i++) begin
      lw[i] = HA;
      lg[i] = HT - HA;
    end
  endtask

  // Sends one frame from lw/lg; coinc_clr pulses clr_err on the cycle the
  // frame-end flags are registered (fv fall seen in s1 at edge N, set at N+2).
  task automatic send_frame(input int n, input bit const_data, input bit coinc_clr);
    logic [15:0] acc;
    bit bad;
    int d;
    exp_t e;
    acc = 0;
    bad = 0;
    for (int k = 0; k < 3; k++) drive(1, 0, 0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < lw[i]; k++) begin
        d = const_data ? 'h3FF : int'($urandom_range(0, 1023));
        acc = acc + 16'(d);
        drive(1, 1, d);
      end
      for (int k = 0; k < lg[i]; k++) drive(1, 0, 0);
      if (lw[i] != HA) begin bad = 1; m_eha = 1; end
      if (i > 0 && (lw[i-1] + lg[i-1]) != HT) begin bad = 1; m_eht = 1; end
    end
    if (n != VA) begin bad = 1; m_eva = 1; end
    m_hact = lw[n-1];
    if (n >= 2) m_htot = lw[n-2] + lg[n-2];
    m_fcnt = m_fcnt + 16'd1;
    m_clean = bad ? 0 : ((m_clean < 15) ? m_clean + 1 : 15);
    e.hact = m_hact; e.htot = m_htot; e.vact = n; e.fcnt = int'(m_fcnt);
`ifdef RAW_FRAME_CHECKSUM_EN
    e.csum = int'(acc);
`else
    e.csum = 0;
`endif
    e.err  = {m_eha, m_eht, m_eva, m_enf};
    e.lock = (m_clean >= LF);
    q_exp.push_back(e);
    for (int k = 0; k < 6; k++) begin
      clr_err = coinc_clr && (k == 2);
      drive(0, 0, 0);
    end
    clr_err = 0;
  endtask

  task automatic clr_pulse();
    clr_err = 1;
    drive(0, 0, 0);
    clr_err = 0;
    m_eha = 0; m_eht = 0; m_eva = 0; m_enf = 0;
  endtask

  task automatic stray_pulse();
    for (int k = 0; k < 3; k++) drive(0, 1, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0);
    m_enf = 1;
    m_clean = 0;
  endtask

  // Compare process: every reported frame against the model, lock one cycle later.
  bit lock_pend;
  bit lock_exp;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      lock_pend = 0;
    end else begin
      if (lock_pend) begin
        check("locked_after_frame", {31'd0, locked}, {31'd0, lock_exp});
        lock_pend = 0;
      end
      if (frame_done) begin
        if (q_exp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame_done: got frame_cnt 0x%0h, expected no frame at %0t", frame_cnt, $time);
        end else begin
          e = q_exp.pop_front();
          check("meas_h_active", 32'(meas_h_active), e.hact);
          check("meas_h_total", 32'(meas_h_total), e.htot);
          check("meas_v_active", 32'(meas_v_active), e.vact);
          check("frame_cnt", 32'(frame_cnt), e.fcnt);
          check("frame_checksum", 32'(frame_checksum), e.csum);
          check("err_flags", {28'd0, err_h_active, err_h_total, err_v_active, err_lv_no_fv}, e.err);
          lock_pend = 1;
          lock_exp = e.lock;
        end
      end
    end
  end

  int n;
  bit seen;

  initial begin
    rstn = 0;
    clr_err = 0;
    vid.fv = 0; vid.lv = 0; vid.data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_meas_h_active", 32'(meas_h_active), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_err_flags", {28'd0, err_h_active, err_h_total, err_v_active, err_lv_no_fv}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_checksum", 32'(frame_checksum), 0);
    rstn = 1;
    for (int k = 0; k < 4; k++) drive(0, 0, 0);

    // Nominal frames.
    set_nominal(4);
    send_frame(4, 0, 0);
    check("nom_locked_f1", {31'd0, locked}, 0);
    send_frame(4, 0, 0);
    check("nom_locked_f2", {31'd0, locked}, 1);
    send_frame(4, 0, 0);
    check("nom_meas_h_active", 32'(meas_h_active), 8);
    check("nom_meas_h_total", 32'(meas_h_total), 12);
    check("nom_meas_v_active", 32'(meas_v_active), 4);
    check("nom_frame_cnt", 32'(frame_cnt), 3);
    check("nom_err_flags", {28'd0, err_h_active, err_h_total, err_v_active, err_lv_no_fv}, 0);

    // Short line: lock must fall the cycle after the width flag rises.
    set_nominal(4);
    lw[1] = 7;
    lg[1] = 5;
    fork
      send_frame(4, 0, 0);
      begin
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          if (err_h_active) seen = 1;
        end
        if (!seen) begin
          n_vec++;
          n_err++;
          $display("FAIL short_line_timeout: got err_h_active 0, expected 1 within 200 cycles");
        end else begin
          check("short_locked_at_flag", {31'd0, locked}, 1);
          check("short_meas_h_active", 32'(meas_h_active), 7);
          @(negedge clk);
          check("short_locked_next", {31'd0, locked}, 0);
        end
      end
    join
    clr_pulse();
    check("clr_err_flags", {28'd0, err_h_active, err_h_total, err_v_active, err_lv_no_fv}, 0);
    set_nominal(4);
    send_frame(4, 0, 0);
    send_frame(4, 0, 0);
    check("relock", {31'd0, locked}, 1);

    // Mid-frame reset: the frame in progress must not be reported.
    for (int k = 0; k < 3; k++) drive(1, 0, 0);
    for (int k = 0; k < 8; k++) drive(1, 1, k);
    rstn = 0;
    model_reset();
    drive(1, 0, 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    check("midrst_locked", {31'd0, locked}, 0);
    check("midrst_meas_h_active", 32'(meas_h_active), 0);
    drive(1, 0, 0);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) drive(1, 1, k);
      for (int k = 0; k < 4; k++) drive(1, 0, 0);
    end
    for (int k = 0; k < 6; k++) drive(0, 0, 0);
    set_nominal(4);
    send_frame(4, 0, 0);
    check("midrst_next_frame_cnt", 32'(frame_cnt), 1);

    // Stray line pulse outside frame valid.
    stray_pulse();
    check("stray_err_lv_no_fv", {31'd0, err_lv_no_fv}, 1);
    send_frame(4, 0, 0);
    check("stray_meas_v_active", 32'(meas_v_active), 4);

    // Set and clear in the same cycle: set wins.
    clr_pulse();
    set_nominal(5);
    send_frame(5, 0, 1);
    check("samecyc_err_v_active", {31'd0, err_v_active}, 1);
    check("samecyc_meas_v_active", 32'(meas_v_active), 5);

    // Checksum with constant full-scale data.
    clr_pulse();
    set_nominal(4);
    send_frame(4, 1, 0);
`ifdef RAW_FRAME_CHECKSUM_EN
    check("checksum_const", 32'(frame_checksum), 32'h7FE0);
`else
    check("checksum_const", 32'(frame_checksum), 0);
`endif

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : VA;
      for (int i = 0; i < n; i++) begin
        lw[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : HA;
        lg[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : HT - lw[i];
      end
      send_frame(n, 0, 0);
      case ($urandom_range(0, 7))
        0: clr_pulse();
        1: stray_pulse();
        default: ;
      endcase
    end

    for (int k = 0; k < 4; k++) drive(0, 0, 0);
    check("all_frames_reported", q_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
